// File: rtl/sum_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_mult_pkg
// Brief    : Shared widths and pipeline-stage type for the (a + b) * c arbiter
// Revision : 1.0
// ============================================================================
package sum_mult_pkg;

  localparam int C_DEF_IN_W   = 128;
  localparam int C_DEF_MULT_W = 32;
  localparam int C_TAG_MAX_W  = 3;   // enough for up to 8 requesters

  // Exact result width: carry-kept adder times multiplier.
  function automatic int sum_width(input int in_w, input int mult_w);
    return in_w + 1 + mult_w;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [C_TAG_MAX_W-1:0] tag;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/sum_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sum_mult_pipe
// Brief    : Two-stage registered (a + b) * c datapath with tag/valid sideband
// Revision : 1.0
// ============================================================================
module sum_mult_pipe
  import sum_mult_pkg::*;
#(
  parameter int IN_W   = C_DEF_IN_W,
  parameter int MULT_W = C_DEF_MULT_W,
  parameter int SUM_W  = sum_width(IN_W, MULT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_W-1:0]   in_a,
  input  logic [IN_W-1:0]   in_b,
  input  logic [MULT_W-1:0] in_c,
  input  stage_t            in_stage,
  output stage_t            s1_stage,
  output stage_t            s2_stage,
  output logic [SUM_W-1:0]  sum
);

  (* keep = "true" *) logic [IN_W-1:0]   r_a;
  (* keep = "true" *) logic [IN_W-1:0]   r_b;
  (* keep = "true" *) logic [MULT_W-1:0] r_c;
  (* keep = "true" *) logic [SUM_W-1:0]  r_sum;
  stage_t r_s1;
  stage_t r_s2;

  logic [IN_W:0]    w_add;
  logic [SUM_W-1:0] w_prod;

  assign w_add  = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod = SUM_W'(w_add) * SUM_W'(r_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_sum <= '0;
      r_s1  <= '0;
      r_s2  <= '0;
    end else if (en) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_c   <= in_c;
      r_s1  <= in_stage;
      r_sum <= w_prod;
      r_s2  <= r_s1;
    end
  end

  assign s1_stage = r_s1;
  assign s2_stage = r_s2;
  assign sum      = r_sum;

endmodule
`default_nettype wire

// File: rtl/sum_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sum_mult_arbiter
// Brief    : Round-robin arbiter feeding a shared (a + b) * c pipeline
// Revision : 1.0
// ============================================================================
module sum_mult_arbiter
  import sum_mult_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int IN_W   = C_DEF_IN_W,
  parameter int MULT_W = C_DEF_MULT_W,
  parameter int SUM_W  = sum_width(IN_W, MULT_W),
  parameter int TAG_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IN_W-1:0]   req_a,
  input  logic [N_REQ*IN_W-1:0]   req_b,
  input  logic [N_REQ*MULT_W-1:0] req_c,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [TAG_W-1:0]        res_tag,
  output logic [SUM_W-1:0]        res_sum,
  output logic                    busy
);

  logic               w_advance;
  logic               w_found;
  logic               w_xfer;
  logic [TAG_W-1:0]   r_rr_ptr;
  logic [TAG_W-1:0]   w_off;
  logic [TAG_W-1:0]   w_grant;
  logic [TAG_W:0]     w_sum_idx;
  logic [2*N_REQ-1:0] w_dbl;
  logic [IN_W-1:0]    w_a;
  logic [IN_W-1:0]    w_b;
  logic [MULT_W-1:0]  w_c;
  stage_t             w_in_stage;
  stage_t             w_s1;
  stage_t             w_s2;
  logic               w_unused;

  assign w_advance = !w_s2.valid | res_ready;

  // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
  assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        w_found = 1'b1;
        w_off   = TAG_W'(j);
      end
    end
  end

  assign w_sum_idx = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_grant   = (w_sum_idx >= (TAG_W+1)'(N_REQ))
                   ? TAG_W'(w_sum_idx - (TAG_W+1)'(N_REQ))
                   : w_sum_idx[TAG_W-1:0];

  // Grants are suppressed while reset is held, even though advance is high then.
  assign w_xfer = w_found & w_advance & !rst;

  always_comb begin
    req_ready = '0;
    w_a       = '0;
    w_b       = '0;
    w_c       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_xfer && (w_grant == TAG_W'(i));
      if (w_grant == TAG_W'(i)) begin
        w_a = req_a[i*IN_W +: IN_W];
        w_b = req_b[i*IN_W +: IN_W];
        w_c = req_c[i*MULT_W +: MULT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_grant == TAG_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
    end
  end

  assign w_in_stage.valid = w_found;
  assign w_in_stage.tag   = C_TAG_MAX_W'(w_grant);

  sum_mult_pipe #(
    .IN_W   (IN_W),
    .MULT_W (MULT_W),
    .SUM_W  (SUM_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (w_advance),
    .in_a     (w_a),
    .in_b     (w_b),
    .in_c     (w_c),
    .in_stage (w_in_stage),
    .s1_stage (w_s1),
    .s2_stage (w_s2),
    .sum      (res_sum)
  );

  assign res_valid = w_s2.valid;
  assign res_tag   = w_s2.tag[TAG_W-1:0];
  assign busy      = w_s1.valid | w_s2.valid;
  assign w_unused  = ^{w_s1.tag, w_s2.tag};

endmodule
`default_nettype wire

// File: tb/tb_sum_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_mult_arbiter
// Brief    : Directed scoreboard bench for the round-robin (a + b) * c arbiter
// Revision : 1.0
// ============================================================================
module tb_sum_mult_arbiter;
  import sum_mult_pkg::*;

  localparam int N_REQ  = 4;
  localparam int IN_W   = 128;
  localparam int MULT_W = 32;
  localparam int SUM_W  = IN_W + 1 + MULT_W;
  localparam int TAG_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*IN_W-1:0]   req_a;
  logic [N_REQ*IN_W-1:0]   req_b;
  logic [N_REQ*MULT_W-1:0] req_c;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [TAG_W-1:0]        res_tag;
  logic [SUM_W-1:0]        res_sum;
  logic                    busy;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [SUM_W-1:0] sum;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr;
  logic m_v1;
  logic m_v2;

  always #5 clk = ~clk;

  sum_mult_arbiter #(
    .N_REQ (N_REQ),
    .IN_W  (IN_W),
    .MULT_W(MULT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_c    (req_c),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_tag  (res_tag),
    .res_sum  (res_sum),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [SUM_W-1:0] obs, input logic [SUM_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] exp_sum(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                                               input logic [MULT_W-1:0] c);
    logic [SUM_W-1:0] x, y, z;
    x = SUM_W'(a);
    y = SUM_W'(b);
    z = SUM_W'(c);
    return (x + y) * z;
  endfunction

  task automatic set_req(input int i, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [MULT_W-1:0] c);
    req_a[i*IN_W +: IN_W]     = a;
    req_b[i*IN_W +: IN_W]     = b;
    req_c[i*MULT_W +: MULT_W] = c;
  endtask

  task automatic rand_all();
    for (int i = 0; i < N_REQ; i++)
      set_req(i, {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, $urandom);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_v1  = 1'b0;
    m_v2  = 1'b0;
    q.delete();
  endtask

  // One clock cycle: entered just after a negedge with inputs already driven.
  task automatic tick(input string name);
    logic             adv, found;
    int               g, idx;
    logic [N_REQ-1:0] er;
    exp_t             e;
    #1;
    adv   = !m_v2 || res_ready;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (m_ptr + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    er = '0;
    if (found && adv) er[g] = 1'b1;
    chk({name, ":req_ready"}, SUM_W'(req_ready), SUM_W'(er));
    chk({name, ":res_valid"}, SUM_W'(res_valid), SUM_W'(m_v2));
    chk({name, ":busy"}, SUM_W'(busy), SUM_W'(m_v1 | m_v2));
    if (m_v2) begin
      chk({name, ":sb_entry"}, SUM_W'(q.size() > 0), SUM_W'(1));
      if (q.size() > 0) begin
        chk({name, ":res_tag"}, SUM_W'(res_tag), SUM_W'(q[0].tag));
        chk({name, ":res_sum"}, res_sum, q[0].sum);
      end
    end
    e.tag = TAG_W'(g);
    e.sum = exp_sum(req_a[g*IN_W +: IN_W], req_b[g*IN_W +: IN_W], req_c[g*MULT_W +: MULT_W]);
    @(posedge clk);
    if (adv) begin
      if (m_v2) void'(q.pop_front());
      m_v2 = m_v1;
      m_v1 = found;
      if (found) begin
        q.push_back(e);
        m_ptr = (g + 1) % N_REQ;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [SUM_W-1:0] big;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    res_ready = 1'b1;
    rand_all();
    repeat (2) @(negedge clk);
    #1;
    chk("rst:req_ready", SUM_W'(req_ready), SUM_W'(0));
    chk("rst:res_valid", SUM_W'(res_valid), SUM_W'(0));
    chk("rst:busy", SUM_W'(busy), SUM_W'(0));
    chk("rst:res_tag", SUM_W'(res_tag), SUM_W'(0));
    chk("rst:res_sum", res_sum, SUM_W'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    model_reset();

    // Single operation from requester 2
    set_req(2, 5, 7, 3);
    req_valid = 4'b0100;
    tick("single");
    req_valid = '0;
    tick("single");
    #1;
    chk("single:valid", SUM_W'(res_valid), SUM_W'(1));
    chk("single:sum36", res_sum, SUM_W'(36));
    chk("single:tag2", SUM_W'(res_tag), SUM_W'(2));
    repeat (2) tick("single");

    // Carry and full-width product
    set_req(0, '1, '1, '1);
    req_valid = 4'b0001;
    tick("carry");
    req_valid = '0;
    tick("carry");
    big = ((SUM_W'(1) << 129) - SUM_W'(2)) * ((SUM_W'(1) << 32) - SUM_W'(1));
    #1;
    chk("carry:sum", res_sum, big);
    chk("carry:topbit", SUM_W'(res_sum[SUM_W-1]), SUM_W'(1));
    repeat (2) tick("carry");

    // Fairness: align pointer to 0 via requester 3, then all valid
    req_valid = 4'b1000;
    tick("fair_align");
    req_valid = '1;
    for (int n = 0; n < 8; n++) begin
      rand_all();
      tick("fair");
    end
    req_valid = '0;
    repeat (3) tick("fair_drain");

    // Backpressure with results pending
    req_valid = '1;
    rand_all();
    repeat (2) tick("bp_fill");
    res_ready = 1'b0;
    rand_all();
    repeat (3) tick("bp_stall");
    res_ready = 1'b1;
    repeat (3) tick("bp_release");
    req_valid = '0;
    repeat (3) tick("bp_drain");

    // Wrap and skip with pointer at 2
    set_req(1, 11, 22, 33);
    set_req(3, 44, 55, 66);
    req_valid = 4'b0010;
    tick("wrap_align");
    req_valid = 4'b1010;
    #1;
    chk("wrap:g3", SUM_W'(req_ready), SUM_W'(4'b1000));
    tick("wrap");
    #1;
    chk("wrap:g1", SUM_W'(req_ready), SUM_W'(4'b0010));
    tick("wrap");
    #1;
    chk("wrap:g3b", SUM_W'(req_ready), SUM_W'(4'b1000));
    tick("wrap");
    req_valid = '0;
    repeat (3) tick("wrap_drain");

    // Asynchronous reset with two operations in flight
    req_valid = '1;
    rand_all();
    repeat (2) tick("ar_fill");
    #2;
    rst = 1'b1;
    #1;
    chk("ar:res_valid", SUM_W'(res_valid), SUM_W'(0));
    chk("ar:busy", SUM_W'(busy), SUM_W'(0));
    chk("ar:req_ready", SUM_W'(req_ready), SUM_W'(0));
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    model_reset();
    repeat (3) tick("ar_quiet");
    req_valid = '1;
    #1;
    chk("ar:first_grant", SUM_W'(req_ready), SUM_W'(4'b0001));
    tick("ar_restart");
    req_valid = '0;
    repeat (3) tick("ar_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
